// File: rtl/rob_pkg.sv
// Shared types and width helpers for the reorder buffer.
package rob_pkg;

    localparam int ROB_DATA_W  = 32;
    localparam int ROB_REG_W   = 5;
    localparam int TAG_INVALID = -1;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic                  redirect;
        logic [ROB_REG_W-1:0]  rd;
        logic [ROB_DATA_W-1:0] val;
        logic [ROB_DATA_W-1:0] next_pc;
    } rob_entry_t;

    function automatic int tag_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return tag_width(depth) + 1;
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Picks the contiguous run of retirable entries starting at head; a redirect ends the run.
module rob_commit_sel #(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = 4
) (
    input  logic [COMMIT_W-1:0] vld_rot,
    input  logic [COMMIT_W-1:0] rdy_rot,
    input  logic [COMMIT_W-1:0] redir_rot,
    output logic [COMMIT_W-1:0] mask,
    output logic [CNT_W-1:0]    n_commit
);

    logic go;

    always_comb begin
        mask     = '0;
        n_commit = '0;
        go       = 1'b1;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (go && vld_rot[k] && rdy_rot[k]) begin
                mask[k]  = 1'b1;
                n_commit = n_commit + CNT_W'(1);
                if (redir_rot[k]) go = 1'b0;
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// In-order reorder buffer: allocate at tail, multi-port writeback, up to COMMIT_W retires per cycle.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 3,
    parameter int COMMIT_W = 2,
    parameter int DATA_W   = ROB_DATA_W,
    parameter int REG_W    = ROB_REG_W,
    localparam int TAG_W   = tag_width(DEPTH),
    localparam int CNT_W   = cnt_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    input  logic [REG_W-1:0]             alloc_rd,
    output logic                         alloc_ready,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
    input  logic [WB_PORTS-1:0]          wb_redirect,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_next_pc,
    input  logic [TAG_W-1:0]             snoop_tag,
    output logic                         snoop_hit,
    output logic [DATA_W-1:0]            snoop_data,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic [COMMIT_W*REG_W-1:0]    commit_rd,
    output logic [COMMIT_W*DATA_W-1:0]   commit_data,
    output logic [COMMIT_W*TAG_W-1:0]    commit_tag,
    output logic                         flush_en,
    output logic [DATA_W-1:0]            flush_pc,
    output logic [CNT_W-1:0]             count
);

    rob_entry_t          entries [DEPTH];
    logic [TAG_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count_q;
    logic [TAG_W-1:0]    slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0] vld_rot, rdy_rot, redir_rot, mask;
    logic [CNT_W-1:0]    n_commit;
    logic                flush_now;
    logic [DATA_W-1:0]   flush_pc_next;
    logic                accept;

    assign count       = count_q;
    assign alloc_tag   = tail;
    assign alloc_ready = (count_q != CNT_W'(DEPTH)) && !flush_en;
    assign accept      = alloc_valid && alloc_ready && !flush_now;
    assign snoop_hit   = entries[snoop_tag].valid && entries[snoop_tag].ready;
    assign snoop_data  = entries[snoop_tag].val;

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k]  = head + TAG_W'(k);
            vld_rot[k]   = entries[slot_idx[k]].valid;
            rdy_rot[k]   = entries[slot_idx[k]].ready;
            redir_rot[k] = entries[slot_idx[k]].redirect;
        end
    end

    rob_commit_sel #(.COMMIT_W(COMMIT_W), .CNT_W(CNT_W)) u_sel (
        .vld_rot   (vld_rot),
        .rdy_rot   (rdy_rot),
        .redir_rot (redir_rot),
        .mask      (mask),
        .n_commit  (n_commit)
    );

    // The selector stops right after a redirect, so at most one retiring slot can flush.
    always_comb begin
        commit_valid  = mask;
        commit_rd     = '0;
        commit_data   = '0;
        commit_tag    = '0;
        flush_now     = 1'b0;
        flush_pc_next = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            commit_rd[k*REG_W +: REG_W]     = entries[slot_idx[k]].rd;
            commit_data[k*DATA_W +: DATA_W] = entries[slot_idx[k]].val;
            commit_tag[k*TAG_W +: TAG_W]    = mask[k] ? slot_idx[k] : TAG_W'(TAG_INVALID);
            if (mask[k] && entries[slot_idx[k]].redirect) begin
                flush_now     = 1'b1;
                flush_pc_next = entries[slot_idx[k]].next_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
            flush_en <= 1'b0;
            flush_pc <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            flush_en <= flush_now;
            if (flush_now) flush_pc <= flush_pc_next;
            if (flush_now) begin
                // Everything younger than the redirect is squashed; the ROB restarts empty.
                for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
                head    <= head + TAG_W'(n_commit);
                tail    <= head + TAG_W'(n_commit);
                count_q <= '0;
            end else begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && entries[wb_tag[p*TAG_W +: TAG_W]].valid) begin
                        entries[wb_tag[p*TAG_W +: TAG_W]].ready    <= 1'b1;
                        entries[wb_tag[p*TAG_W +: TAG_W]].redirect <= wb_redirect[p];
                        entries[wb_tag[p*TAG_W +: TAG_W]].val      <= wb_data[p*DATA_W +: DATA_W];
                        entries[wb_tag[p*TAG_W +: TAG_W]].next_pc  <= wb_next_pc[p*DATA_W +: DATA_W];
                    end
                end
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (mask[k]) entries[slot_idx[k]].valid <= 1'b0;
                end
                if (accept) begin
                    entries[tail].valid    <= 1'b1;
                    entries[tail].ready    <= 1'b0;
                    entries[tail].redirect <= 1'b0;
                    entries[tail].rd       <= alloc_rd;
                    tail                   <= tail + TAG_W'(1);
                end
                head    <= head + TAG_W'(n_commit);
                count_q <= count_q + CNT_W'(accept) - n_commit;
            end
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport with hand-computed expectations and an expected-commit queue.
module tb_rob_multiport;

    localparam int DEPTH = 8, WBP = 3, CW = 2, DW = 32, RW = 5, TW = 3, CNTW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid;
    logic [RW-1:0]     alloc_rd;
    logic              alloc_ready;
    logic [TW-1:0]     alloc_tag;
    logic [WBP-1:0]    wb_valid;
    logic [WBP*TW-1:0] wb_tag;
    logic [WBP*DW-1:0] wb_data;
    logic [WBP-1:0]    wb_redirect;
    logic [WBP*DW-1:0] wb_next_pc;
    logic [TW-1:0]     snoop_tag;
    logic              snoop_hit;
    logic [DW-1:0]     snoop_data;
    logic [CW-1:0]     commit_valid;
    logic [CW*RW-1:0]  commit_rd;
    logic [CW*DW-1:0]  commit_data;
    logic [CW*TW-1:0]  commit_tag;
    logic              flush_en;
    logic [DW-1:0]     flush_pc;
    logic [CNTW-1:0]   count;

    int checks = 0;
    int errors = 0;
    int n_commits = 0;
    logic [DW-1:0] exp_q[$];

    rob_multiport dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_redirect(wb_redirect), .wb_next_pc(wb_next_pc),
        .snoop_tag(snoop_tag), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .flush_en(flush_en), .flush_pc(flush_pc), .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid    = '0;
        wb_tag      = '0;
        wb_data     = '0;
        wb_redirect = '0;
        wb_next_pc  = '0;
    endtask

    task automatic set_wb(input int p, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                          input logic redir, input logic [DW-1:0] npc);
        wb_valid[p]            = 1'b1;
        wb_tag[p*TW +: TW]     = tag;
        wb_data[p*DW +: DW]    = data;
        wb_redirect[p]         = redir;
        wb_next_pc[p*DW +: DW] = npc;
    endtask

    // scoreboard: compare slot 0 retirement against the oldest expected value
    task automatic check_commit0(input string tag);
        logic [DW-1:0] e;
        if (commit_valid[0]) begin
            n_commits++;
            if (exp_q.size() == 0) begin
                chk({tag, "_unexpected"}, 64'(commit_data[DW-1:0]), 64'hdead);
            end else begin
                e = exp_q.pop_front();
                chk(tag, 64'(commit_data[DW-1:0]), 64'(e));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0;
        alloc_rd = '0;
        snoop_tag = '0;
        clear_wb();
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_flush_en", 64'(flush_en), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);

        // fill all eight entries
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1;
            alloc_rd = RW'(i + 1);
            chk("fill_tag", 64'(alloc_tag), 64'(i));
            chk("fill_ready", 64'(alloc_ready), 64'd1);
            tick();
        end
        chk("full_count", 64'(count), 64'd8);
        chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
        tick();
        chk("ninth_ignored_count", 64'(count), 64'd8);
        alloc_valid = 1'b0;

        // tags 1 and 0 complete together, retire as a pair in order
        set_wb(0, 3'd1, 32'h11, 1'b0, 32'h0);
        set_wb(1, 3'd0, 32'h10, 1'b0, 32'h0);
        tick();
        clear_wb();
        snoop_tag = 3'd0;
        #1;
        chk("pair_commit_valid", 64'(commit_valid), 64'b11);
        chk("pair_data0", 64'(commit_data[DW-1:0]), 64'h10);
        chk("pair_data1", 64'(commit_data[2*DW-1:DW]), 64'h11);
        chk("pair_tag0", 64'(commit_tag[TW-1:0]), 64'd0);
        chk("pair_tag1", 64'(commit_tag[2*TW-1:TW]), 64'd1);
        chk("pair_rd1", 64'(commit_rd[2*RW-1:RW]), 64'd2);
        chk("snoop_hit", 64'(snoop_hit), 64'd1);
        chk("snoop_data", 64'(snoop_data), 64'h10);
        tick();
        chk("pair_count", 64'(count), 64'd6);
        chk("pair_after_valid", 64'(commit_valid), 64'd0);

        // tag 3 done while tag 2 still pending: nothing retires
        set_wb(1, 3'd3, 32'h33, 1'b0, 32'h0);
        tick();
        clear_wb();
        chk("hold_commit_valid", 64'(commit_valid), 64'd0);
        tick();
        chk("hold_commit_valid2", 64'(commit_valid), 64'd0);
        chk("hold_count", 64'(count), 64'd6);

        // ports 0 and 2 both write tag 2: the higher port's value lands
        set_wb(0, 3'd2, 32'hA, 1'b0, 32'h0);
        set_wb(2, 3'd2, 32'hB, 1'b0, 32'h0);
        tick();
        clear_wb();
        chk("prio_commit_valid", 64'(commit_valid), 64'b11);
        chk("prio_data0", 64'(commit_data[DW-1:0]), 64'hB);
        chk("prio_tag0", 64'(commit_tag[TW-1:0]), 64'd2);
        chk("prio_data1", 64'(commit_data[2*DW-1:DW]), 64'h33);
        tick();
        chk("prio_count", 64'(count), 64'd4);

        // redirect at tag 4 blocks tag 5 from retiring with it
        set_wb(0, 3'd4, 32'h44, 1'b1, 32'h80);
        set_wb(1, 3'd5, 32'h55, 1'b0, 32'h0);
        tick();
        clear_wb();
        chk("redir_commit_valid", 64'(commit_valid), 64'b01);
        chk("redir_tag0", 64'(commit_tag[TW-1:0]), 64'd4);
        chk("redir_data0", 64'(commit_data[DW-1:0]), 64'h44);
        chk("redir_no_flush_yet", 64'(flush_en), 64'd0);
        alloc_valid = 1'b1;
        alloc_rd = 5'd9;
        tick();
        alloc_valid = 1'b0;
        chk("flush_en", 64'(flush_en), 64'd1);
        chk("flush_pc", 64'(flush_pc), 64'h80);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("flush_commit_valid", 64'(commit_valid), 64'd0);
        tick();
        chk("post_flush_en", 64'(flush_en), 64'd0);
        chk("post_flush_ready", 64'(alloc_ready), 64'd1);
        chk("post_flush_tag", 64'(alloc_tag), 64'd5);
        chk("post_flush_count", 64'(count), 64'd0);

        // wrap: one alloc and one writeback per cycle for 20 entries
        for (int i = 0; i < 20; i++) begin
            clear_wb();
            alloc_valid = 1'b1;
            alloc_rd = 5'd1;
            if (i > 0) begin
                set_wb(0, TW'(5 + i - 1), 32'h100 + DW'(i - 1), 1'b0, 32'h0);
                exp_q.push_back(32'h100 + DW'(i - 1));
            end
            chk("wrap_tag", 64'(alloc_tag), 64'((5 + i) % DEPTH));
            chk("wrap_count_le2", 64'(count <= 4'd2), 64'd1);
            check_commit0("wrap_commit");
            tick();
        end
        alloc_valid = 1'b0;
        clear_wb();
        set_wb(0, 3'd0, 32'h113, 1'b0, 32'h0);
        exp_q.push_back(32'h113);
        check_commit0("drain_commit");
        tick();
        clear_wb();
        check_commit0("drain_commit");
        tick();
        chk("wrap_commits", 64'(n_commits), 64'd20);
        chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("wrap_final_count", 64'(count), 64'd0);

        // reset in the middle of activity
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1;
            alloc_rd = RW'(i + 3);
            tick();
        end
        alloc_valid = 1'b0;
        set_wb(0, 3'd1, 32'h77, 1'b0, 32'h0);
        chk("pre_rst_count", 64'(count), 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_wb();
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("mid_rst_flush_en", 64'(flush_en), 64'd0);
        chk("mid_rst_alloc_tag", 64'(alloc_tag), 64'd0);
        tick();
        chk("mid_rst_commit_valid2", 64'(commit_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
